cfg_bus_router: RTL and testbench
=================================

# cfg_bus_router

Parametrised localbus configuration router for the match pipeline. Decodes each localbus address phase, forwards a one-cycle address strobe to one of NUM_CH downstream configuration targets (search engines, rule lookup), and returns the selected target's acknowledge and read data to the host. Unlike a fixed-fan-out router, it:
- responds only to the addressed channel;
- answers unmapped selects with an error word;
- times out silent targets;
- counts errors.

## Interface
Parameters:
- NUM_CH, 5: number of downstream targets, 1..16.
- SEL_LSB, 16: LSB of the channel-select field in localbus_data.
- SEL_W, 4: select field width; NUM_CH must be ≤ 2^SEL_W.
- LOCAL_BIT, 23: address bit that must be 0 for this block to claim the access.
- TIMEOUT, 1024: cycles to wait for a target ack; ≥ 2.
- ERR_DATA, 32'hDEAD_BEEF: read data returned on unmapped or timeout.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- localbus_cs_n  in  1  host chip select, active low.
- localbus_rd_wr  in  1  host direction; not used for routing (targets sample it directly).
- localbus_data  in  32  host address/write data.
- localbus_ale  in  1  host address-latch strobe.
- localbus_ack_n  out  1  acknowledge to host, active low.
- localbus_data_out  out  32  read data to host.
- ch_ale  out  NUM_CH  per-target address strobe; bit i drives target i.
- ch_ack_n  in  NUM_CH  per-target acknowledge, active low.
- ch_data_out  in  32*NUM_CH  per-target read data; target i occupies [32i+31:32i].
- err_pulse  out  1  one-cycle pulse on each unmapped or timeout completion.
- err_cnt  out  16  saturating count of error completions.

## Operation
- The reset value of every output and register is applied at a rising clk edge while reset=0:
  - state=IDLE;
  - localbus_ack_n=1, localbus_data_out=0;
  - ch_ale=0;
  - err_pulse=0, err_cnt=0;
  - timer and latched select = 0.
- **IDLE**
  - Claim condition: localbus_ale=1 and localbus_data[LOCAL_BIT]=0.
  - On claim, latch sel = localbus_data[SEL_LSB +: SEL_W].
  - If sel < NUM_CH:
    - ch_ale[sel]<=1 for exactly one cycle;
    - timer<=0;
    - go to WAIT_ACK.
  - Otherwise (unmapped):
    - localbus_ack_n<=0, localbus_data_out<=ERR_DATA;
    - err_pulse<=1, err_cnt increments;
    - go to WAIT_REL.
  - If localbus_ale=1 with localbus_data[LOCAL_BIT]=1, the access is ignored and state stays IDLE.
- **WAIT_ACK**
  - ch_ale<=0.
  - Only ch_ack_n[sel] is examined; acks on other channels are ignored.
  - If ch_ack_n[sel]=0: localbus_ack_n<=0, localbus_data_out<=ch_data_out[sel], go to WAIT_REL.
  - Else if timer = TIMEOUT-1: localbus_ack_n<=0, localbus_data_out<=ERR_DATA, err_pulse<=1, err_cnt increments, go to WAIT_REL.
  - Else timer<=timer+1.
- **WAIT_REL**
  - localbus_ack_n stays 0 and localbus_data_out is held.
  - When localbus_cs_n=1: localbus_ack_n<=1, go to IDLE.
  - localbus_data_out keeps its last value; it is not cleared.
- localbus_ale in WAIT_ACK or WAIT_REL is ignored; no queuing.
- err_pulse is 0 on every cycle other than the error-completion cycle.
- err_cnt saturates at 16'hFFFF and clears only on reset.
- Reset asserted mid-transaction forces reset values on the next edge, including deasserting ack and ch_ale; the in-flight access is dropped.
- Timer width is sized to hold TIMEOUT-1.

## Timing
Cycle 0 is the edge that samples localbus_ale=1.
- Mapped access:
  - ch_ale[sel]=1 during cycle 1 only.
  - If the target drives ch_ack_n[sel]=0 sampled at edge k (k ≥ 1), localbus_ack_n=0 and data are valid from cycle k+1.
- Unmapped access: localbus_ack_n=0 with ERR_DATA from cycle 1.
- Timeout: localbus_ack_n=0 with ERR_DATA from cycle TIMEOUT+1. An ack arriving at the same edge as the timeout wins (data from the target, no error).
- Release: localbus_cs_n=1 sampled at edge r gives localbus_ack_n=1 from cycle r+1. The earliest next claim is edge r+1.
- A target ack held low beyond the transaction has no effect outside WAIT_ACK.

## Test plan
- Mapped read: NUM_CH=5, localbus_data=32'h0002_0000 with ale. Target 2 acks 3 cycles later with data 32'h1234_5678 → ch_ale=5'b00100 for one cycle; localbus_ack_n low one cycle after the target ack with data 32'h1234_5678; ack_n high one cycle after cs_n rises.
- Unmapped select: localbus_data[19:16]=4'd9 → no ch_ale; ack_n low at cycle 1 with 32'hDEAD_BEEF; err_pulse one cycle; err_cnt=1.
- Foreign access: localbus_data[23]=1 with ale → no ch_ale, no ack, state stays IDLE.
- Timeout: TIMEOUT=8, target 0 never acks → ack_n low at cycle 9 with ERR_DATA; err_cnt increments. Also cover ack at exactly the timeout edge → target data returned, err_cnt unchanged.
- Stray ack: access to channel 1 while channel 3 holds ch_ack_n low → ignored; completion occurs only on channel 1's ack. A second ale during WAIT_REL is ignored.
- Mid-transaction reset: reset=0 while in WAIT_REL → localbus_ack_n=1, localbus_data_out=0, err_cnt=0 the next cycle.

Source files
------------

// File: rtl/cfg_bus_router.sv
// Localbus configuration router: decodes the address phase, strobes one of NUM_CH
// targets, returns its ack/data, and answers unmapped or silent targets with ERR_DATA.
module cfg_bus_router #(
    parameter int          NUM_CH    = 5,
    parameter int          SEL_LSB   = 16,
    parameter int          SEL_W     = 4,
    parameter int          LOCAL_BIT = 23,
    parameter int          TIMEOUT   = 1024,
    parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 localbus_cs_n,
    input  logic                 localbus_rd_wr,
    input  logic [31:0]          localbus_data,
    input  logic                 localbus_ale,
    output logic                 localbus_ack_n,
    output logic [31:0]          localbus_data_out,
    output logic [NUM_CH-1:0]    ch_ale,
    input  logic [NUM_CH-1:0]    ch_ack_n,
    input  logic [32*NUM_CH-1:0] ch_data_out,
    output logic                 err_pulse,
    output logic [15:0]          err_cnt
);

    localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_REL} state_t;

    state_t              state_q, state_d;
    logic [SEL_W-1:0]    sel_q, sel_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic                ack_n_q, ack_n_d;
    logic [31:0]         data_q, data_d;
    logic [NUM_CH-1:0]   ch_ale_q, ch_ale_d;
    logic                err_pulse_q, err_pulse_d;
    logic [15:0]         err_cnt_q, err_cnt_d;

    logic [SEL_W-1:0]    sel_in;
    logic                claim, mapped, err_done;
    logic                sel_ack_n;
    logic [31:0]         sel_data;

    // The direction bit is sampled by the targets themselves; only a few address bits route.
    logic unused_ok;
    assign unused_ok = ^{localbus_rd_wr, localbus_data};

    assign sel_in = localbus_data[SEL_LSB +: SEL_W];
    assign claim  = localbus_ale && !localbus_data[LOCAL_BIT];
    assign mapped = {1'b0, sel_in} < (SEL_W + 1)'(NUM_CH);

    // Explicit mux keeps selects beyond NUM_CH from indexing past the vectors.
    always_comb begin
        sel_ack_n = 1'b1;
        sel_data  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (sel_q == SEL_W'(i)) begin
                sel_ack_n = ch_ack_n[i];
                sel_data  = ch_data_out[32*i +: 32];
            end
        end
    end

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        timer_d     = timer_q;
        ack_n_d     = ack_n_q;
        data_d      = data_q;
        ch_ale_d    = '0;
        err_pulse_d = 1'b0;
        err_done    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (claim) begin
                    sel_d = sel_in;
                    if (mapped) begin
                        for (int i = 0; i < NUM_CH; i++) begin
                            ch_ale_d[i] = (sel_in == SEL_W'(i));
                        end
                        timer_d = '0;
                        state_d = WAIT_ACK;
                    end else begin
                        err_done = 1'b1;
                    end
                end
            end
            WAIT_ACK: begin
                if (!sel_ack_n) begin
                    ack_n_d = 1'b0;
                    data_d  = sel_data;
                    state_d = WAIT_REL;
                end else if (timer_q == TMR_LAST) begin
                    err_done = 1'b1;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_REL: begin
                if (localbus_cs_n) begin
                    ack_n_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (err_done) begin
            ack_n_d     = 1'b0;
            data_d      = ERR_DATA;
            err_pulse_d = 1'b1;
            state_d     = WAIT_REL;
        end
        err_cnt_d = (err_done && err_cnt_q != 16'hFFFF) ? err_cnt_q + 16'd1 : err_cnt_q;
    end

    // NOTE: state registers use non-blocking assignments so all update together at the edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            timer_q     <= '0;
            ack_n_q     <= 1'b1;
            data_q      <= '0;
            ch_ale_q    <= '0;
            err_pulse_q <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            timer_q     <= timer_d;
            ack_n_q     <= ack_n_d;
            data_q      <= data_d;
            ch_ale_q    <= ch_ale_d;
            err_pulse_q <= err_pulse_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign localbus_ack_n    = ack_n_q;
    assign localbus_data_out = data_q;
    assign ch_ale            = ch_ale_q;
    assign err_pulse         = err_pulse_q;
    assign err_cnt           = err_cnt_q;

endmodule

// File: tb/tb_cfg_bus_router.sv
// Bench for cfg_bus_router: directed scenarios with literal expectations, then random
// traffic, all compared every cycle against a transaction-level model of the router.
module tb_cfg_bus_router;

    localparam int          NUM_CH    = 5;
    localparam int          SEL_LSB   = 16;
    localparam int          LOCAL_BIT = 23;
    localparam int          TIMEOUT   = 8;
    localparam logic [31:0] ERR       = 32'hDEAD_BEEF;

    logic                 clk = 1'b0;
    logic                 reset = 1'b0;
    logic                 cs_n = 1'b1;
    logic                 rd_wr = 1'b1;
    logic [31:0]          data = '0;
    logic                 ale = 1'b0;
    logic                 ack_n;
    logic [31:0]          data_out;
    logic [NUM_CH-1:0]    ch_ale;
    logic [NUM_CH-1:0]    ch_ack_n = '1;
    logic [32*NUM_CH-1:0] ch_data = '0;
    logic                 err_pulse;
    logic [15:0]          err_cnt;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    cfg_bus_router #(
        .NUM_CH(NUM_CH), .SEL_LSB(SEL_LSB), .SEL_W(4), .LOCAL_BIT(LOCAL_BIT),
        .TIMEOUT(TIMEOUT), .ERR_DATA(ERR)
    ) dut (
        .clk(clk), .reset(reset),
        .localbus_cs_n(cs_n), .localbus_rd_wr(rd_wr), .localbus_data(data),
        .localbus_ale(ale), .localbus_ack_n(ack_n), .localbus_data_out(data_out),
        .ch_ale(ch_ale), .ch_ack_n(ch_ack_n), .ch_data_out(ch_data),
        .err_pulse(err_pulse), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Transaction-level model: which channel is outstanding, when it was claimed,
    // and whether a completed access is being held until cs_n rises.
    int          pend_ch = -1;
    int          claim_cyc = 0;
    int          cyc = 0;
    bit          holding = 1'b0;
    logic        exp_ack_n = 1'b1;
    logic [31:0] exp_data = '0;
    logic [NUM_CH-1:0] exp_ale = '0;
    logic        exp_err = 1'b0;
    logic [15:0] exp_cnt = '0;

    always @(posedge clk) begin
        int  s;
        bit  done, is_err;
        logic [31:0] rdata;
        cyc++;
        done = 1'b0; is_err = 1'b0; rdata = '0;
        if (!reset) begin
            pend_ch = -1; holding = 1'b0;
            exp_ack_n = 1'b1; exp_data = '0; exp_ale = '0; exp_err = 1'b0; exp_cnt = '0;
        end else begin
            exp_ale = '0;
            exp_err = 1'b0;
            if (holding) begin
                if (cs_n) begin
                    exp_ack_n = 1'b1;
                    holding = 1'b0;
                end
            end else if (pend_ch >= 0) begin
                if (!ch_ack_n[pend_ch]) begin
                    done = 1'b1; rdata = ch_data[32*pend_ch +: 32];
                end else if (cyc - claim_cyc == TIMEOUT) begin
                    done = 1'b1; is_err = 1'b1; rdata = ERR;
                end
            end else if (ale && !data[LOCAL_BIT]) begin
                s = int'(data[SEL_LSB +: 4]);
                if (s < NUM_CH) begin
                    exp_ale[s] = 1'b1;
                    pend_ch = s;
                    claim_cyc = cyc;
                end else begin
                    done = 1'b1; is_err = 1'b1; rdata = ERR;
                end
            end
            if (done) begin
                exp_ack_n = 1'b0;
                exp_data = rdata;
                holding = 1'b1;
                pend_ch = -1;
                if (is_err) begin
                    exp_err = 1'b1;
                    if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_ack_n", ack_n, exp_ack_n);
            check("cmp_data_out", data_out, exp_data);
            check("cmp_ch_ale", ch_ale, exp_ale);
            check("cmp_err_pulse", err_pulse, exp_err);
            check("cmp_err_cnt", err_cnt, exp_cnt);
        end
    end

    task automatic start_access(input logic [31:0] addr);
        cs_n = 1'b0; ale = 1'b1; data = addr;
        tick();
        ale = 1'b0;
    endtask

    task automatic release_bus();
        cs_n = 1'b1;
        tick();
        check("release_ack_n", ack_n, 1'b1);
    endtask

    initial begin
        int n;
        tick(); tick();
        cmp_en = 1'b1;
        check("rst_ack_n", ack_n, 1'b1);
        check("rst_data_out", data_out, 32'h0);
        check("rst_ch_ale", ch_ale, 5'b00000);
        check("rst_err_cnt", err_cnt, 16'd0);
        reset = 1'b1;
        tick();

        // Mapped read on channel 2.
        start_access(32'h0002_0000);
        check("map_ale_on", ch_ale, 5'b00100);
        tick();
        check("map_ale_off", ch_ale, 5'b00000);
        tick();
        check("map_no_ack_yet", ack_n, 1'b1);
        ch_data[64 +: 32] = 32'h1234_5678;
        ch_ack_n[2] = 1'b0;
        tick();
        ch_ack_n[2] = 1'b1;
        check("map_ack_n", ack_n, 1'b0);
        check("map_data", data_out, 32'h1234_5678);
        release_bus();
        check("map_data_held", data_out, 32'h1234_5678);

        // Unmapped select 9.
        start_access(32'h0009_0000);
        check("unm_ack_n", ack_n, 1'b0);
        check("unm_data", data_out, 32'hDEAD_BEEF);
        check("unm_err_pulse", err_pulse, 1'b1);
        check("unm_err_cnt", err_cnt, 16'd1);
        check("unm_ch_ale", ch_ale, 5'b00000);
        tick();
        check("unm_pulse_once", err_pulse, 1'b0);
        release_bus();

        // Foreign access (bit 23 set).
        start_access(32'h0082_0000);
        check("for_ch_ale", ch_ale, 5'b00000);
        tick();
        check("for_ack_n", ack_n, 1'b1);
        cs_n = 1'b1;
        tick();

        // Timeout on channel 0.
        start_access(32'h0000_0000);
        n = 0;
        while (ack_n && n < 20) begin
            tick();
            n++;
        end
        check("to_latency", n, TIMEOUT);
        check("to_data", data_out, 32'hDEAD_BEEF);
        check("to_err_cnt", err_cnt, 16'd2);
        release_bus();

        // Ack on the timeout edge wins.
        ch_data[0 +: 32] = 32'hCAFE_0001;
        start_access(32'h0000_0000);
        repeat (TIMEOUT - 1) tick();
        check("toe_still_waiting", ack_n, 1'b1);
        ch_ack_n[0] = 1'b0;
        tick();
        ch_ack_n[0] = 1'b1;
        check("toe_ack_n", ack_n, 1'b0);
        check("toe_data", data_out, 32'hCAFE_0001);
        check("toe_no_err", err_pulse, 1'b0);
        check("toe_err_cnt", err_cnt, 16'd2);
        release_bus();

        // Stray ack on channel 3 while channel 1 is addressed; second ale in WAIT_REL.
        ch_ack_n[3] = 1'b0;
        ch_data[32 +: 32] = 32'h0000_1111;
        start_access(32'h0001_0000);
        repeat (3) tick();
        check("stray_ignored", ack_n, 1'b1);
        ch_ack_n[1] = 1'b0;
        tick();
        ch_ack_n[1] = 1'b1;
        check("stray_ack_n", ack_n, 1'b0);
        check("stray_data", data_out, 32'h0000_1111);
        ale = 1'b1; data = 32'h0002_0000;
        tick();
        ale = 1'b0;
        check("rel_ale_ignored", ch_ale, 5'b00000);
        check("rel_ack_held", ack_n, 1'b0);
        ch_ack_n[3] = 1'b1;
        release_bus();

        // Reset while holding an error completion.
        start_access(32'h000F_0000);
        check("mr_err_cnt_pre", err_cnt, 16'd3);
        reset = 1'b0;
        tick();
        check("mr_ack_n", ack_n, 1'b1);
        check("mr_data", data_out, 32'h0);
        check("mr_err_cnt", err_cnt, 16'd0);
        reset = 1'b1;
        cs_n = 1'b1;
        tick();

        // Random traffic against the model.
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 199) != 0);
            cs_n  = ($urandom_range(0, 3) == 0);
            ale   = ($urandom_range(0, 3) == 0);
            data  = $urandom;
            data[SEL_LSB +: 4] = 4'($urandom_range(0, 7));
            data[LOCAL_BIT] = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NUM_CH; i++) begin
                ch_ack_n[i] = ($urandom_range(0, 7) != 0);
                ch_data[32*i +: 32] = $urandom;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
